// File: rtl/de_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller.
// Holds the branch FSM encoding and the default sizing parameters.
// No logic; imported by the scoreboard and the top module.
package de_hazard_ctrl_pkg;

    // Architectural register index width (RV32 style, x0..x31)
    localparam int REG_IDX_W      = 5;

    // Default sizing for the hazard controller
    localparam int NUM_REGS_DEF   = 32;
    localparam int CNT_BITS_DEF   = 2;
    localparam int WDOG_LIMIT_DEF = 64;

    // Branch FSM encoding, visible externally on br_state
    typedef enum logic [1:0] {
        BR_IDLE  = 2'd0,
        BR_WAIT  = 2'd1,
        BR_FLUSH = 2'd2
    } br_state_e;

endpackage

// File: rtl/de_scoreboard.sv
// Per-register pending-write counters plus operand readiness / hazard detection.
// Hazard outputs are combinational (zero cycle); counters update on the next rising edge.
// No backpressure of its own: the parent gates increments with the issue decision.
module de_scoreboard
    import de_hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_i,
    input  logic [REG_IDX_W-1:0] inc_rd_i,
    input  logic                 wb_wr_reg_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic                 rs1_used_i,
    input  logic                 rs2_used_i,
    input  logic                 de_wr_reg_i,
    input  logic [REG_IDX_W-1:0] de_rd_i,
    output logic                 raw_hazard_o,
    output logic                 struct_hazard_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [CNT_BITS-1:0] cnt_q [NUM_REGS];
    logic [CNT_BITS-1:0] cnt_d [NUM_REGS];

    logic inc_en;
    logic dec_en;
    logic rs1_rdy;
    logic rs2_rdy;

    // x0 is never counted, so writes and writebacks to it are dropped here
    assign inc_en = inc_i & (inc_rd_i != '0);
    assign dec_en = wb_wr_reg_i & (wb_rd_i != '0);

    // An operand with exactly one outstanding write that retires this cycle is
    // ready: the register file writes on the falling edge, ahead of the read.
    assign rs1_rdy = (rs1_i == '0) || (cnt_q[rs1_i] == '0) ||
                     ((cnt_q[rs1_i] == CNT_ONE) && wb_wr_reg_i && (wb_rd_i == rs1_i));
    assign rs2_rdy = (rs2_i == '0) || (cnt_q[rs2_i] == '0) ||
                     ((cnt_q[rs2_i] == CNT_ONE) && wb_wr_reg_i && (wb_rd_i == rs2_i));

    assign raw_hazard_o    = (rs1_used_i & ~rs1_rdy) | (rs2_used_i & ~rs2_rdy);
    assign struct_hazard_o = de_wr_reg_i & (de_rd_i != '0) & (cnt_q[de_rd_i] == CNT_MAX);

    // Next counter values: +1 on issue, -1 on writeback, both cancel, never wrap
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            logic inc_hit;
            logic dec_hit;
            inc_hit = inc_en && (inc_rd_i == REG_IDX_W'(r)) && (cnt_q[r] != CNT_MAX);
            dec_hit = dec_en && (wb_rd_i == REG_IDX_W'(r)) && (cnt_q[r] != '0);
            if (inc_en && dec_en && (inc_rd_i == REG_IDX_W'(r)) && (wb_rd_i == REG_IDX_W'(r))) begin
                cnt_d[r] = cnt_q[r];
            end else if (inc_hit) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_hit) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    // Counter array register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: rtl/de_hazard_ctrl.sv
// Decode-stage hazard control: RAW/structural stalls, branch hold/flush FSM, wait watchdog.
// issue/stall/flush are combinational from current state and de_* (zero-cycle latency).
// Stalls decode on hazards, agex_busy or any in-flight branch; fetch is also held while a branch waits.
module de_hazard_ctrl
    import de_hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int CNT_BITS   = CNT_BITS_DEF,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       de_valid,
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    input  logic       de_rs1_used,
    input  logic       de_rs2_used,
    input  logic [4:0] de_rd,
    input  logic       de_wr_reg,
    input  logic       de_is_br,
    input  logic       wb_wr_reg,
    input  logic [4:0] wb_rd,
    input  logic       agex_busy,
    input  logic       br_resolve,
    output logic       issue,
    output logic       stall_de,
    output logic       stall_fe,
    output logic       flush_de,
    output logic [1:0] br_state,
    output logic       wdog_err
);

    localparam int                WCNT_W   = $clog2(WDOG_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WDOG_LIMIT);

    br_state_e         state_q;
    br_state_e         state_d;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [WCNT_W-1:0] wait_cnt_d;
    logic              wdog_err_q;
    logic              wdog_err_d;
    logic              raw_hazard;
    logic              struct_hazard;
    logic              sb_inc;

    assign sb_inc = issue & de_wr_reg;

    de_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_BITS (CNT_BITS)
    ) u_sb (
        .clk             (clk),
        .reset           (reset),
        .inc_i           (sb_inc),
        .inc_rd_i        (de_rd),
        .wb_wr_reg_i     (wb_wr_reg),
        .wb_rd_i         (wb_rd),
        .rs1_i           (de_rs1),
        .rs2_i           (de_rs2),
        .rs1_used_i      (de_rs1_used),
        .rs2_used_i      (de_rs2_used),
        .de_wr_reg_i     (de_wr_reg),
        .de_rd_i         (de_rd),
        .raw_hazard_o    (raw_hazard),
        .struct_hazard_o (struct_hazard)
    );

    // Branch FSM state register; reset abandons any in-flight branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch FSM next state: wait for resolve, then flush decode for one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BR_IDLE:  if (issue && de_is_br) state_d = BR_WAIT;
            BR_WAIT:  if (br_resolve)        state_d = BR_FLUSH;
            BR_FLUSH:                        state_d = BR_IDLE;
            default:                         state_d = BR_IDLE;
        endcase
    end

    // Issue/stall/flush outputs, purely from current state and decode inputs
    always_comb begin
        stall_de = de_valid & (raw_hazard | struct_hazard | agex_busy | (state_q != BR_IDLE));
        issue    = de_valid & ~stall_de;
        stall_fe = stall_de | (issue & de_is_br) | (state_q == BR_WAIT);
        flush_de = (state_q == BR_FLUSH);
        br_state = state_q;
        wdog_err = wdog_err_q;
    end

    // Wait counter: zeroed on branch entry, counts every BR_WAIT cycle, saturates;
    // the error flag latches once the limit is reached and holds until reset
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q == BR_IDLE) && (state_d == BR_WAIT)) begin
            wait_cnt_d = '0;
        end else if ((state_q == BR_WAIT) && (wait_cnt_q != WCNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
        wdog_err_d = wdog_err_q | ((state_q == BR_WAIT) && (wait_cnt_d == WCNT_MAX));
    end

    // Watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

endmodule

// File: tb/tb_de_hazard_ctrl.sv
// Self-checking bench for de_hazard_ctrl: directed scenarios plus randomized traffic.
// Expected values come from a pending-write count model kept as plain integers.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_de_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       de_valid;
    logic [4:0] de_rs1;
    logic [4:0] de_rs2;
    logic       de_rs1_used;
    logic       de_rs2_used;
    logic [4:0] de_rd;
    logic       de_wr_reg;
    logic       de_is_br;
    logic       wb_wr_reg;
    logic [4:0] wb_rd;
    logic       agex_busy;
    logic       br_resolve;
    logic       issue;
    logic       stall_de;
    logic       stall_fe;
    logic       flush_de;
    logic [1:0] br_state;
    logic       wdog_err;

    de_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .de_valid    (de_valid),
        .de_rs1      (de_rs1),
        .de_rs2      (de_rs2),
        .de_rs1_used (de_rs1_used),
        .de_rs2_used (de_rs2_used),
        .de_rd       (de_rd),
        .de_wr_reg   (de_wr_reg),
        .de_is_br    (de_is_br),
        .wb_wr_reg   (wb_wr_reg),
        .wb_rd       (wb_rd),
        .agex_busy   (agex_busy),
        .br_resolve  (br_resolve),
        .issue       (issue),
        .stall_de    (stall_de),
        .stall_fe    (stall_fe),
        .flush_de    (flush_de),
        .br_state    (br_state),
        .wdog_err    (wdog_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outstanding writes per register, branch phase, wait cycles
    int pend [32];
    int m_state;      // 0 idle, 1 waiting for resolve, 2 flushing
    int m_wait;
    bit m_err;

    // Outputs captured at the last sample point, for directed spot checks
    logic got_issue, got_stall_de, got_stall_fe, got_flush, got_wdog;
    logic [1:0] got_state;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(input logic [4:0] rs, input bit wbw, input logic [4:0] wbrd);
        return (rs == 0) || (pend[rs] == 0) || (pend[rs] == 1 && wbw && wbrd == rs);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_state = 0;
        m_wait  = 0;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic step(input bit v, input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2,
                        input logic [4:0] rd, input bit wr, input bit br,
                        input bit wbw, input logic [4:0] wbrd,
                        input bit busy, input bit res);
        bit raw, strh, e_stall, e_issue, e_fe;
        @(negedge clk);
        de_valid = v;  de_rs1 = rs1; de_rs1_used = u1; de_rs2 = rs2; de_rs2_used = u2;
        de_rd = rd;    de_wr_reg = wr; de_is_br = br;
        wb_wr_reg = wbw; wb_rd = wbrd; agex_busy = busy; br_resolve = res;
        #1;
        raw     = (u1 && !model_ready(rs1, wbw, wbrd)) || (u2 && !model_ready(rs2, wbw, wbrd));
        strh    = wr && (rd != 0) && (pend[rd] >= 3);
        e_stall = v && (raw || strh || busy || m_state != 0);
        e_issue = v && !e_stall;
        e_fe    = e_stall || (e_issue && br) || (m_state == 1);

        got_issue = issue; got_stall_de = stall_de; got_stall_fe = stall_fe;
        got_flush = flush_de; got_state = br_state; got_wdog = wdog_err;

        check_eq("issue",    32'(issue),    32'(e_issue));
        check_eq("stall_de", 32'(stall_de), 32'(e_stall));
        check_eq("stall_fe", 32'(stall_fe), 32'(e_fe));
        check_eq("flush_de", 32'(flush_de), 32'(m_state == 2));
        check_eq("br_state", 32'(br_state), 32'(m_state));
        check_eq("wdog_err", 32'(wdog_err), 32'(m_err));

        // Advance the model to the state after the coming rising edge
        if (e_issue && wr && rd != 0) pend[rd] = pend[rd] + 1;
        if (wbw && wbrd != 0 && pend[wbrd] > 0) pend[wbrd] = pend[wbrd] - 1;
        case (m_state)
            0: if (e_issue && br) begin m_state = 1; m_wait = 0; end
            1: begin
                if (m_wait < 64) m_wait = m_wait + 1;
                if (m_wait >= 64) m_err = 1'b1;
                if (res) m_state = 2;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb_only(input logic [4:0] r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; all outputs must be quiet while held
    task automatic do_reset();
        @(negedge clk);
        de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
        de_rd = 0; de_wr_reg = 0; de_is_br = 0; wb_wr_reg = 0; wb_rd = 0;
        agex_busy = 0; br_resolve = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_issue",    32'(issue),    32'(0));
        check_eq("rst_stall_de", 32'(stall_de), 32'(0));
        check_eq("rst_stall_fe", 32'(stall_fe), 32'(0));
        check_eq("rst_flush",    32'(flush_de), 32'(0));
        check_eq("rst_br_state", 32'(br_state), 32'(0));
        check_eq("rst_wdog",     32'(wdog_err), 32'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        do_reset();

        // Back-to-back RAW on x5, released by the writeback cycle
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        check_eq("raw_first_issue", 32'(got_issue), 32'(1));
        step(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        check_eq("raw_stall", 32'(got_stall_de), 32'(1));
        step(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 6, 0, 0, 1, 5, 0, 0);
        check_eq("raw_release_issue", 32'(got_issue), 32'(1));

        // x0 destinations are never counted and x0 sources never stall
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check_eq("x0_fourth_write", 32'(got_issue), 32'(1));
        step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("x0_read", 32'(got_stall_de), 32'(0));

        // Counter saturation on x7: fourth write stalls until one writeback
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        check_eq("sat_struct_stall", 32'(got_stall_de), 32'(1));
        wb_only(7);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        check_eq("sat_after_wb", 32'(got_issue), 32'(1));
        for (int i = 0; i < 3; i++) wb_only(7);

        // Same-cycle issue and writeback of x9 with one pending leaves one pending
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 1, 9, 0, 0);
        step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("sim_x9_still_pending", 32'(got_stall_de), 32'(1));
        step(1, 9, 1, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        check_eq("sim_x9_single_wb", 32'(got_issue), 32'(1));

        // Branch: hold fetch, resolve after 5 cycles, one flush cycle
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        check_eq("br_stall_fe", 32'(got_stall_fe), 32'(1));
        idle(5);
        check_eq("br_waiting", 32'(got_state), 32'(1));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check_eq("br_flush", 32'(got_flush), 32'(1));
        idle(1);
        check_eq("br_flush_once", 32'(got_flush), 32'(0));
        check_eq("br_back_idle", 32'(got_state), 32'(0));
        wb_only(1);

        // Watchdog: 64 unresolved cycles set a sticky error, reset clears it
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(64);
        check_eq("wdog_not_yet", 32'(got_wdog), 32'(0));
        idle(1);
        check_eq("wdog_set", 32'(got_wdog), 32'(1));
        idle(10);
        check_eq("wdog_held", 32'(got_wdog), 32'(1));
        do_reset();
        idle(1);

        // Reset taken during the flush cycle: no flush after release
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        idle(2);
        check_eq("rst_mid_flush", 32'(got_flush), 32'(0));

        // Randomized traffic over x0..x7; writebacks only target pending registers
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] rs1, rs2, rd, wbrd;
            bit wbw;
            int cands [$];
            cands.delete();
            for (int r = 1; r < 8; r++) if (pend[r] > 0) cands.push_back(r);
            wbw  = (cands.size() > 0) && ($urandom_range(0, 1) == 1);
            wbrd = wbw ? 5'(cands[$urandom_range(0, cands.size() - 1)]) : 5'($urandom_range(0, 7));
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            rd   = 5'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 8, rs1, $urandom_range(0, 1) == 1,
                 rs2, $urandom_range(0, 1) == 1, rd, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, wbw, wbrd,
                 $urandom_range(0, 19) < 3, $urandom_range(0, 19) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
